// File: rtl/ram_copy_engine.sv
// rtl/ram_copy_engine.sv - word-at-a-time block copy within a single-port RAM with XOR checksum
module ram_copy_engine #(
   parameter int AW = 8,
   parameter int DW = 64,
   parameter int LW = 9
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic [AW-1:0] src_addr,
   input  logic [AW-1:0] dst_addr,
   input  logic [LW-1:0] len,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] checksum,
   output logic          mem_cen,
   output logic          mem_wen,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_din,
   input  logic [DW-1:0] mem_dout
);

   typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;

   // Longest legal copy is the whole RAM; larger requests are clamped to it.
   localparam logic [LW-1:0] MAX_LEN = LW'(2**AW);

   state_t        state, state_d;
   logic [AW-1:0] src_q, src_d;
   logic [AW-1:0] dst_q, dst_d;
   logic [LW-1:0] len_q, len_d;
   logic [LW-1:0] idx, idx_d;
   logic [LW-1:0] idx_inc;
   logic          busy_d, done_d, cen_d, wen_d;
   logic [DW-1:0] checksum_d, din_d;
   logic [AW-1:0] addr_d;

   assign idx_inc = idx + LW'(1);

   // Next-state and next-output logic; mem_din doubles as the data buffer.
   always_comb begin
      state_d    = state;
      src_d      = src_q;
      dst_d      = dst_q;
      len_d      = len_q;
      idx_d      = idx;
      busy_d     = busy;
      done_d     = 1'b0;
      checksum_d = checksum;
      cen_d      = 1'b0;
      wen_d      = 1'b0;
      addr_d     = mem_addr;
      din_d      = mem_din;
      case (state)
         IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               src_d      = src_addr;
               dst_d      = dst_addr;
               len_d      = (len > MAX_LEN) ? MAX_LEN : len;
               idx_d      = '0;
               checksum_d = '0;
               if (len == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = RD;
                  busy_d  = 1'b1;
                  cen_d   = 1'b1;
                  addr_d  = src_addr;
               end
            end
         end
         RD: begin
            state_d = CAP;
         end
         CAP: begin
            state_d    = WR;
            din_d      = mem_dout;
            checksum_d = checksum ^ mem_dout;
            cen_d      = 1'b1;
            wen_d      = 1'b1;
            addr_d     = dst_q + idx[AW-1:0];
         end
         WR: begin
            idx_d = idx_inc;
            if (idx_inc < len_q) begin
               state_d = RD;
               cen_d   = 1'b1;
               addr_d  = src_q + idx_inc[AW-1:0];
            end else begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State, operand and registered-output update; reset aborts any copy in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         src_q    <= '0;
         dst_q    <= '0;
         len_q    <= '0;
         idx      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         checksum <= '0;
         mem_cen  <= 1'b0;
         mem_wen  <= 1'b0;
         mem_addr <= '0;
         mem_din  <= '0;
      end else begin
         state    <= state_d;
         src_q    <= src_d;
         dst_q    <= dst_d;
         len_q    <= len_d;
         idx      <= idx_d;
         busy     <= busy_d;
         done     <= done_d;
         checksum <= checksum_d;
         mem_cen  <= cen_d;
         mem_wen  <= wen_d;
         mem_addr <= addr_d;
         mem_din  <= din_d;
      end
   end

endmodule

// File: tb/tb_ram_copy_engine.sv
// tb/tb_ram_copy_engine.sv - scoreboard bench for ram_copy_engine
module tb_ram_copy_engine;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  src_addr = '0;
   logic [7:0]  dst_addr = '0;
   logic [8:0]  len = '0;
   logic        busy, done, mem_cen, mem_wen;
   logic [63:0] checksum, mem_din;
   logic [7:0]  mem_addr;
   logic [63:0] mem_dout = '0;

   logic [63:0] ram [256];
   logic [63:0] ref_mem [256];
   logic        pre_we = 1'b0;
   logic [7:0]  pre_addr = '0;
   logic [63:0] pre_data = '0;

   logic [71:0] obs_q [$];
   logic [7:0]  addr_q [$];

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   ram_copy_engine #(.AW(8), .DW(64), .LW(9)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .src_addr(src_addr),
      .dst_addr(dst_addr), .len(len), .busy(busy), .done(done),
      .checksum(checksum), .mem_cen(mem_cen), .mem_wen(mem_wen),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
   );

   // RAM model with registered read data and a bench-side preload port.
   always @(posedge clk) begin
      if (pre_we) ram[pre_addr] <= pre_data;
      else if (mem_cen && mem_wen) begin
         ram[mem_addr] <= mem_din;
         obs_q.push_back({mem_addr, mem_din});
      end
      if (mem_cen && !mem_wen) mem_dout <= ram[mem_addr];
      else mem_dout <= '0;
      if (mem_cen) addr_q.push_back(mem_addr);
   end

   task automatic preload(input logic [7:0] a, input logic [63:0] d);
      pre_we = 1'b1; pre_addr = a; pre_data = d;
      ref_mem[a] = d;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [8:0] n,
                           input bit poke, input string tag);
      logic [71:0] exp_q [$];
      logic [63:0] exp_chk = '0;
      int eff = (n > 9'd256) ? 256 : int'(n);
      int obs0 = obs_q.size();
      int bc = 0;
      bit got = 0, both = 0;
      for (int i = 0; i < eff; i++) begin
         logic [7:0] a = s + 8'(i);
         logic [7:0] w = d + 8'(i);
         exp_chk ^= ref_mem[a];
         exp_q.push_back({w, ref_mem[a]});
         ref_mem[w] = ref_mem[a];
      end
      @(negedge clk);
      start = 1'b1; src_addr = s; dst_addr = d; len = n;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         if (busy && done) both = 1;
         if (busy) bc++;
         if (done) begin got = 1; break; end
         if (poke && bc == 2) begin
            start = 1'b1; src_addr = 8'd50; dst_addr = 8'd60; len = 9'd4;
         end else start = 1'b0;
         @(negedge clk);
      end
      start = 1'b0;
      checks++; if (got !== 1'b1) $display("FAIL %s done_seen got %0d want 1", tag, got); else passed++;
      checks++; if (bc !== 3*eff) $display("FAIL %s busy_cycles got %0d want %0d", tag, bc, 3*eff); else passed++;
      checks++; if (both !== 1'b0) $display("FAIL %s busy_and_done got 1 want 0", tag); else passed++;
      checks++; if (checksum !== exp_chk) $display("FAIL %s checksum got %h want %h", tag, checksum, exp_chk); else passed++;
      @(negedge clk);
      checks++; if (done !== 1'b0) $display("FAIL %s done_width got %b want 0", tag, done); else passed++;
      checks++; if (obs_q.size() - obs0 !== eff) $display("FAIL %s write_count got %0d want %0d", tag, obs_q.size() - obs0, eff); else passed++;
      for (int i = 0; i < eff && obs0 + i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[obs0+i] !== exp_q[i]) $display("FAIL %s write%0d got %h want %h", tag, i, obs_q[obs0+i], exp_q[i]);
         else passed++;
      end
   endtask

   task automatic test_reset;
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, mem_cen, mem_wen, mem_addr, checksum, mem_din} !== '0)
         $display("FAIL reset_state got %b%b%b%b %h %h %h want all zero", busy, done, mem_cen, mem_wen, mem_addr, checksum, mem_din);
      else passed++;
      @(negedge clk); reset_n = 1'b1;
      for (int i = 0; i < 256; i++) preload(8'(i), 64'h5A00_0000_0000_0000 | 64'(i));
   endtask

   task automatic test_basic;
      preload(8'd0, 64'h11); preload(8'd1, 64'h22); preload(8'd2, 64'h33); preload(8'd3, 64'h44);
      run_copy(8'd0, 8'd16, 9'd4, 0, "basic");
      checks++; if (checksum !== 64'h44) $display("FAIL basic_const_checksum got %h want 44", checksum); else passed++;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (ram[16+i] !== 64'(8'h11 * (i + 1))) $display("FAIL basic_mem%0d got %h want %h", i, ram[16+i], 64'(8'h11 * (i + 1)));
         else passed++;
      end
   endtask

   task automatic test_reset_midcopy;
      int obs0 = obs_q.size();
      bit saw = 0;
      @(negedge clk);
      start = 1'b1; src_addr = 8'd2; dst_addr = 8'd40; len = 9'd4;
      @(negedge clk);
      start = 1'b0;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, mem_cen, mem_wen, mem_addr, checksum, mem_din} !== '0)
         $display("FAIL abort_state got %b%b%b%b %h %h %h want all zero", busy, done, mem_cen, mem_wen, mem_addr, checksum, mem_din);
      else passed++;
      @(negedge clk); reset_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (done || busy) saw = 1;
         @(negedge clk);
      end
      checks++; if (saw !== 1'b0) $display("FAIL abort_quiet got 1 want 0"); else passed++;
      checks++; if (obs_q.size() !== obs0) $display("FAIL abort_writes got %0d want 0", obs_q.size() - obs0); else passed++;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (ram[40+i] !== ref_mem[40+i]) $display("FAIL abort_mem%0d got %h want %h", i, ram[40+i], ref_mem[40+i]);
         else passed++;
      end
   endtask

   task automatic test_wrap;
      logic [7:0] exp_a [6] = '{8'd254, 8'd100, 8'd255, 8'd101, 8'd0, 8'd102};
      int a0;
      preload(8'd254, 64'hAAAA_0001); preload(8'd255, 64'hBBBB_0002); preload(8'd0, 64'hCCCC_0003);
      a0 = addr_q.size();
      run_copy(8'd254, 8'd100, 9'd3, 0, "wrap");
      checks++; if (addr_q.size() - a0 !== 6) $display("FAIL wrap_addr_count got %0d want 6", addr_q.size() - a0); else passed++;
      for (int i = 0; i < 6 && a0 + i < addr_q.size(); i++) begin
         checks++;
         if (addr_q[a0+i] !== exp_a[i]) $display("FAIL wrap_addr%0d got %0d want %0d", i, addr_q[a0+i], exp_a[i]);
         else passed++;
      end
      checks++; if (ram[102] !== 64'hCCCC_0003) $display("FAIL wrap_mem102 got %h want CCCC0003", ram[102]); else passed++;
   endtask

   task automatic test_len0_and_busy_start;
      int a0 = addr_q.size();
      run_copy(8'd5, 8'd200, 9'd0, 0, "len0");
      checks++; if (addr_q.size() !== a0) $display("FAIL len0_cen got %0d want 0", addr_q.size() - a0); else passed++;
      checks++; if (checksum !== 64'h0) $display("FAIL len0_checksum got %h want 0", checksum); else passed++;
      run_copy(8'd0, 8'd30, 9'd2, 1, "busy_start");
      checks++; if (ram[60] !== ref_mem[60]) $display("FAIL busy_start_untouched got %h want %h", ram[60], ref_mem[60]); else passed++;
   endtask

   task automatic test_overlap;
      preload(8'd10, 64'hDEAD); preload(8'd11, 64'h1); preload(8'd12, 64'h2); preload(8'd13, 64'h3);
      run_copy(8'd10, 8'd11, 9'd3, 0, "overlap");
      checks++; if (checksum !== 64'hDEAD) $display("FAIL overlap_const_checksum got %h want DEAD", checksum); else passed++;
      for (int i = 11; i <= 13; i++) begin
         checks++;
         if (ram[i] !== 64'hDEAD) $display("FAIL overlap_mem%0d got %h want DEAD", i, ram[i]); else passed++;
      end
   endtask

   task automatic test_full;
      logic [63:0] snap [256];
      bit same;
      for (int i = 0; i < 256; i++) preload(8'(i), {$urandom, $urandom});
      for (int i = 0; i < 256; i++) snap[i] = ref_mem[i];
      run_copy(8'd0, 8'd0, 9'd256, 0, "full");
      same = 1;
      for (int i = 0; i < 256; i++) if (ram[i] !== snap[i]) same = 0;
      checks++; if (same !== 1'b1) $display("FAIL full_unchanged got 0 want 1"); else passed++;
      run_copy(8'd0, 8'd0, 9'd400, 0, "clamp");
   endtask

   initial begin
      test_reset;
      test_basic;
      test_reset_midcopy;
      test_wrap;
      test_len0_and_busy_start;
      test_overlap;
      test_full;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
